// File: rtl/cpu_pkg.sv
// Shared core types and constants for the fetch front end.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int INSN_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSN_W-1:0] INSN_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } pc_insn_t;

    typedef enum logic {
        FQ_RUN,
        FQ_DRAIN
    } fq_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response, core-side handshake, redirect.
interface ifetch_queue_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INSN_W-1:0] imem_rdata;
    logic              ins_valid;
    logic [INSN_W-1:0] ins_data;
    logic [XLEN-1:0]   ins_pc;
    logic              ins_ready;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output ins_valid, ins_data, ins_pc,
        input  ins_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  ins_valid, ins_data, ins_pc,
        output ins_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head is presented directly from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != CW'(DEPTH)) && !flush;
    assign do_pop  = pop && (cnt != '0) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign count    = cnt;
    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited prefetch into a FIFO, redirect flush with in-flight discard.
// Latency: response word reaches ins_valid the cycle after imem_rvalid (no bypass).
// Backpressure: requests stop once outstanding + queued reaches DEPTH; ins_ready stalls the head.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_nxt;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    fq_state_e       state;
    fq_state_e       state_nxt;
    pc_insn_t        head;
    pc_insn_t        push_ent;

    logic req;
    logic gnt_fire;
    logic rsp_fire;
    logic drop_rsp;
    logic push;
    logic pop;

    // Discarded in-flight requests still hold a credit until their response returns.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign req         = !rst && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign gnt_fire    = req && bus.imem_gnt;
    assign rsp_fire    = bus.imem_rvalid && (outstanding != '0);
    assign drop_rsp    = rsp_fire && (state == FQ_DRAIN);
    assign push        = rsp_fire && !drop_rsp && !bus.redirect_valid;
    assign pop         = bus.ins_valid && bus.ins_ready && !bus.redirect_valid;

    assign push_ent.pc   = resp_pc;
    assign push_ent.insn = bus.imem_rdata;

    always_comb begin
        outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(rsp_fire);
        discard_nxt     = discard;
        if (bus.redirect_valid)
            discard_nxt = outstanding - CW'(rsp_fire);
        else if (drop_rsp)
            discard_nxt = discard - CW'(1);
        state_nxt = (discard_nxt != '0) ? FQ_DRAIN : FQ_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FQ_RUN;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc <= word_align(bus.redirect_pc);
            resp_pc  <= word_align(bus.redirect_pc);
        end else begin
            if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
            if (push)     resp_pc  <= resp_pc + 32'd4;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pc_insn_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (bus.redirect_valid),
        .count    (count),
        .head_dat (head)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.ins_valid = (count != '0);
    assign bus.ins_pc    = head.pc;
    assign bus.ins_data  = bus.ins_valid ? head.insn : INSN_NOP;

endmodule
